// File: rtl/x_micro_sequencer_pkg.sv
// x_micro_sequencer_pkg: shared widths, sequencer commands and recorder states.
package x_micro_sequencer_pkg;
  localparam int DATA_W = 36;
  localparam int CMD_W = 4;
  localparam int ADDR_W = 9;
  localparam int WORD_W = DATA_W + CMD_W;
  typedef enum logic [CMD_W-1:0] {
    CMD_DAT = 4'd0,
    CMD_DEL = 4'd1,
    CMD_END = 4'd2
  } cmd_e;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REC,
    ST_FLUSH,
    ST_DONE
  } rec_state_e;
endpackage

// File: rtl/x_micro_sequencer_ram.sv
// x_micro_sequencer_ram: 512 x {data, cmd} program store, one write port, registered read-old read port.
module x_micro_sequencer_ram
  import x_micro_sequencer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;
  // The array itself is never reset so a reset keeps the last recording readable.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else rdata_q <= mem[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/x_micro_recorder.sv
// x_micro_recorder: records a 36-bit bus as a DAT/DEL/END sequencer program.
// X_MICRO_RECORDER_COMPRESS_EN enables DEL run-length compression; otherwise every REC cycle stores a DAT.
module x_micro_recorder
  import x_micro_sequencer_pkg::*;
#(
  parameter int DEL_W = 17
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_full,
  output logic [ADDR_W:0]   o_len,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic [CMD_W-1:0]  o_rcmd
);
  localparam logic [ADDR_W-1:0] LAST = '1;
  rec_state_e state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic full_q, full_d;
  logic we;
  logic [CMD_W-1:0] wcmd;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] waddr;
  logic [WORD_W-1:0] rword;
  logic go;
`ifdef X_MICRO_RECORDER_COMPRESS_EN
  localparam logic [DEL_W-1:0] CNT_MAX = '1;
  logic [DATA_W-1:0] prev_q, prev_d, pend_q, pend_d;
  logic pend_v_q, pend_v_d;
  logic [DEL_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic same;
`endif

  if (DEL_W < 2 || DEL_W > DATA_W) begin : g_bad_del_w
    $error("DEL_W must lie in 2..DATA_W");
  end

  assign go = (state_q == ST_IDLE || state_q == ST_DONE) && i_start;

  always_comb begin
    state_d = state_q;
    len_d = len_q;
    full_d = full_q;
    we = 1'b0;
    wcmd = CMD_DAT;
    wdata = i_data;
    waddr = go ? '0 : len_q[ADDR_W-1:0];
`ifdef X_MICRO_RECORDER_COMPRESS_EN
    prev_d = prev_q;
    pend_v_d = pend_v_q;
    pend_d = pend_q;
    cnt_d = cnt_q;
    same = i_data == prev_q;
    cnt_inc = cnt_q + DEL_W'(1);
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          we = 1'b1;
          full_d = 1'b0;
          state_d = ST_REC;
`ifdef X_MICRO_RECORDER_COMPRESS_EN
          prev_d = i_data;
          cnt_d = '0;
          pend_v_d = 1'b0;
`endif
        end
      end
      ST_REC: begin
        state_d = i_stop ? ST_FLUSH : ST_REC;
`ifdef X_MICRO_RECORDER_COMPRESS_EN
        // A queued DAT owns the port this cycle; cnt is always 0 while it is queued.
        if (pend_v_q) begin
          we = 1'b1;
          wdata = pend_q;
          pend_v_d = 1'b0;
        end
        if (same) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX && !pend_v_q) begin
            we = 1'b1;
            wcmd = CMD_DEL;
            wdata = DATA_W'(cnt_inc);
            cnt_d = '0;
          end
        end else begin
          prev_d = i_data;
          cnt_d = '0;
          if (pend_v_q || cnt_q != '0) begin
            pend_v_d = 1'b1;
            pend_d = i_data;
          end
          if (!pend_v_q) begin
            we = 1'b1;
            wcmd = cnt_q != '0 ? CMD_DEL : CMD_DAT;
            wdata = cnt_q != '0 ? DATA_W'(cnt_q) : i_data;
          end
        end
`else
        we = 1'b1;
`endif
      end
      ST_FLUSH: begin
        we = 1'b1;
        wcmd = CMD_END;
        wdata = '0;
`ifdef X_MICRO_RECORDER_COMPRESS_EN
        if (pend_v_q) begin
          wcmd = CMD_DAT;
          wdata = pend_q;
          pend_v_d = 1'b0;
        end else if (cnt_q != '0) begin
          wcmd = CMD_DEL;
          wdata = DATA_W'(cnt_q);
          cnt_d = '0;
        end else begin
          state_d = ST_DONE;
        end
`else
        state_d = ST_DONE;
`endif
      end
      default: ;
    endcase
    // The last RAM word is always END, whatever was due there.
    if (we) begin
      len_d = (ADDR_W+1)'(waddr) + (ADDR_W+1)'(1);
      if (waddr == LAST) begin
        wcmd = CMD_END;
        wdata = '0;
        full_d = 1'b1;
        state_d = ST_DONE;
`ifdef X_MICRO_RECORDER_COMPRESS_EN
        pend_v_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      len_q <= '0;
      full_q <= 1'b0;
`ifdef X_MICRO_RECORDER_COMPRESS_EN
      prev_q <= '0;
      pend_q <= '0;
      pend_v_q <= 1'b0;
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      full_q <= full_d;
`ifdef X_MICRO_RECORDER_COMPRESS_EN
      prev_q <= prev_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      cnt_q <= cnt_d;
`endif
    end
  end

  x_micro_sequencer_ram u_ram (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i({wdata, wcmd}),
    .raddr_i(i_raddr),
    .rdata_o(rword)
  );

  assign o_rdata = rword[WORD_W-1:CMD_W];
  assign o_rcmd = rword[CMD_W-1:0];
  assign o_busy = state_q == ST_REC || state_q == ST_FLUSH;
  assign o_full = full_q;
  assign o_len = len_q;
endmodule

// File: tb/tb_x_micro_recorder.sv
// tb_x_micro_recorder: directed checks of x_micro_recorder, with or without X_MICRO_RECORDER_COMPRESS_EN.
module tb_x_micro_recorder;
  import x_micro_sequencer_pkg::*;
  localparam int DW = 8;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_start = 1'b0;
  logic i_stop = 1'b0;
  logic [DATA_W-1:0] i_data = '0;
  logic [ADDR_W-1:0] i_raddr = '0;
  logic o_busy, o_full;
  logic [ADDR_W:0] o_len;
  logic [DATA_W-1:0] o_rdata;
  logic [CMD_W-1:0] o_rcmd;
  int checks = 0;
  int fails = 0;
  logic [DATA_W-1:0] va;

  x_micro_recorder #(.DEL_W(DW)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_stop (i_stop),
    .i_data (i_data),
    .o_busy (o_busy),
    .o_full (o_full),
    .o_len  (o_len),
    .i_raddr(i_raddr),
    .o_rdata(o_rdata),
    .o_rcmd (o_rcmd)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_rec(input logic [DATA_W-1:0] d);
    i_data = d;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic feed(input logic [DATA_W-1:0] d);
    i_data = d;
    tick();
  endtask

  task automatic stop_with(input logic [DATA_W-1:0] d);
    i_data = d;
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
  endtask

  task automatic ent(input int a, input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] d);
    i_raddr = ADDR_W'(a);
    tick();
    chk($sformatf("cmd@%0d", a), 64'(o_rcmd), 64'(c));
    chk($sformatf("data@%0d", a), 64'(o_rdata), 64'(d));
  endtask

  initial begin
    #12;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_full", 64'(o_full), 64'd0);
    chk("rst_len", 64'(o_len), 64'd0);
    chk("rst_rdata", 64'(o_rdata), 64'd0);
    chk("rst_rcmd", 64'(o_rcmd), 64'd0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Constant value then stop.
`ifdef X_MICRO_RECORDER_COMPRESS_EN
    va = 36'hA;
    start_rec(va);
    chk("a_busy", 64'(o_busy), 64'd1);
    chk("a_len1", 64'(o_len), 64'd1);
    repeat (4) feed(va);
    stop_with(va);
    chk("a_busy_stop", 64'(o_busy), 64'd1);
    tick();
    chk("a_busy_flush", 64'(o_busy), 64'd1);
    tick();
    chk("a_busy_done", 64'(o_busy), 64'd0);
    chk("a_len", 64'(o_len), 64'd3);
    ent(0, CMD_DAT, va);
    ent(1, CMD_DEL, 36'd5);
    ent(2, CMD_END, 36'd0);
`else
    va = 36'h5;
    start_rec(va);
    chk("a_busy", 64'(o_busy), 64'd1);
    chk("a_len1", 64'(o_len), 64'd1);
    repeat (3) feed(va);
    stop_with(va);
    chk("a_busy_stop", 64'(o_busy), 64'd1);
    tick();
    chk("a_busy_done", 64'(o_busy), 64'd0);
    chk("a_len", 64'(o_len), 64'd6);
    for (int i = 0; i < 5; i++) ent(i, CMD_DAT, va);
    ent(5, CMD_END, 36'd0);
`endif

    // 1,2,3 on consecutive cycles; the start edge also reads address 0 while writing it.
    i_raddr = '0;
    start_rec(36'd1);
    chk("b_rd_old_cmd", 64'(o_rcmd), 64'(CMD_DAT));
    chk("b_rd_old_data", 64'(o_rdata), 64'(va));
    feed(36'd2);
    stop_with(36'd3);
    tick();
    chk("b_busy", 64'(o_busy), 64'd0);
    chk("b_len", 64'(o_len), 64'd4);
    ent(0, CMD_DAT, 36'd1);
    ent(1, CMD_DAT, 36'd2);
    ent(2, CMD_DAT, 36'd3);
    ent(3, CMD_END, 36'd0);

    // Hold then two changes, the last one on the stop cycle.
    start_rec(36'd7);
    feed(36'd7);
    feed(36'd7);
    feed(36'd8);
    stop_with(36'd9);
    repeat (3) tick();
    chk("c_busy", 64'(o_busy), 64'd0);
`ifdef X_MICRO_RECORDER_COMPRESS_EN
    chk("c_len", 64'(o_len), 64'd5);
    ent(0, CMD_DAT, 36'd7);
    ent(1, CMD_DEL, 36'd2);
    ent(2, CMD_DAT, 36'd8);
    ent(3, CMD_DAT, 36'd9);
    ent(4, CMD_END, 36'd0);

    // Counter saturation: 2^DW+1 cycles of one value.
    start_rec(36'h3C);
    repeat (255) feed(36'h3C);
    stop_with(36'h3C);
    repeat (3) tick();
    chk("d_len", 64'(o_len), 64'd4);
    ent(0, CMD_DAT, 36'h3C);
    ent(1, CMD_DEL, 36'd255);
    ent(2, CMD_DEL, 36'd1);
    ent(3, CMD_END, 36'd0);
`else
    chk("c_len", 64'(o_len), 64'd6);
    for (int i = 0; i < 3; i++) ent(i, CMD_DAT, 36'd7);
    ent(3, CMD_DAT, 36'd8);
    ent(4, CMD_DAT, 36'd9);
    ent(5, CMD_END, 36'd0);
`endif

    // Fill the RAM with a value changing every cycle.
    start_rec(36'd0);
    for (int k = 1; k < 600; k++) begin
      feed(DATA_W'(k));
      if (k == 510) begin
        chk("e_full_510", 64'(o_full), 64'd0);
        chk("e_busy_510", 64'(o_busy), 64'd1);
      end
      if (k == 511) chk("e_full_511", 64'(o_full), 64'd1);
    end
    chk("e_full", 64'(o_full), 64'd1);
    chk("e_len", 64'(o_len), 64'd512);
    chk("e_busy", 64'(o_busy), 64'd0);
    stop_with(36'd1);
    chk("e_stop_busy", 64'(o_busy), 64'd0);
    chk("e_stop_len", 64'(o_len), 64'd512);
    ent(0, CMD_DAT, 36'd0);
    ent(510, CMD_DAT, 36'd510);
    ent(511, CMD_END, 36'd0);

    // Restart clears full; reset mid-recording abandons it and keeps RAM.
    start_rec(36'd1);
    chk("f_full_clr", 64'(o_full), 64'd0);
    chk("f_len", 64'(o_len), 64'd1);
    feed(36'd2);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("f_rst_busy", 64'(o_busy), 64'd0);
    chk("f_rst_len", 64'(o_len), 64'd0);
    chk("f_rst_rdata", 64'(o_rdata), 64'd0);
    chk("f_rst_rcmd", 64'(o_rcmd), 64'd0);
    #2;
    i_rst_n = 1'b1;
    ent(0, CMD_DAT, 36'd1);
    ent(1, CMD_DAT, 36'd2);
    ent(2, CMD_DAT, 36'd2);
    chk("f_idle_busy", 64'(o_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
